// File: rtl/isp_pkg.sv
// Shared definitions for the ISP front-end: capture FSM encoding and raw pixel width.
package isp_pkg;
    localparam int RAW_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SKIP   = 2'd1,
        ST_ACTIVE = 2'd2
    } isp_state_e;
endpackage

// File: rtl/isp_edge_det.sv
// Single-bit edge detector: one-cycle pulse on a rising (FALL=0) or falling (FALL=1) edge.
module isp_edge_det #(
    parameter bit FALL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sig,
    output logic o_pulse
);
    logic r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_prev <= 1'b0;
        else       r_prev <= i_sig;
    end

    assign o_pulse = FALL ? (~i_sig & r_prev) : (i_sig & ~r_prev);
endmodule

// File: rtl/isp_raw_capture.sv
// Raw8 DVP capture: crops a fixed window, discards settling frames after reset,
// forwards whole frames only and flags short lines/frames.
module isp_raw_capture
    import isp_pkg::*;
#(
    parameter int source_h    = 1024,
    parameter int source_v    = 1024,
    parameter int x_off       = 0,
    parameter int y_off       = 0,
    parameter int skip_frames = 2,
    parameter int cnt_w       = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             capture_en,
    input  logic             err_clr,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [RAW_W-1:0] cam_data,
    output logic             out_vsync,
    output logic             out_hsync,
    output logic             out_den,
    output logic [RAW_W-1:0] out_data,
    output logic [15:0]      frame_cnt,
    output logic             err_short_line,
    output logic             err_short_frame
);
    localparam int SKW = $clog2(skip_frames + 2);
    localparam logic [SKW-1:0]   SKIP_N = SKW'(skip_frames);
    localparam logic [cnt_w-1:0] X_OFF  = cnt_w'(x_off);
    localparam logic [cnt_w-1:0] Y_OFF  = cnt_w'(y_off);
    localparam logic [cnt_w-1:0] SRC_H  = cnt_w'(source_h);
    localparam logic [cnt_w-1:0] SRC_V  = cnt_w'(source_v);
    localparam logic [cnt_w-1:0] X_END  = cnt_w'(x_off + source_h);

    isp_state_e       r_state, w_next;
    logic [SKW-1:0]   r_skip;
    logic             w_skip_inc;
    logic [cnt_w-1:0] r_col, r_row, r_rows_out;
    logic             w_vs_rise, w_href_fall;
    logic             w_row_in, w_col_in, w_keep, w_row_end;

    isp_edge_det #(.FALL(1'b0)) u_vs_edge (
        .clk(clk), .reset(reset), .i_sig(cam_vsync), .o_pulse(w_vs_rise)
    );
    isp_edge_det #(.FALL(1'b1)) u_href_edge (
        .clk(clk), .reset(reset), .i_sig(cam_href), .o_pulse(w_href_fall)
    );

    // Offset subtraction wraps below the window, so one unsigned compare covers both bounds.
    assign w_row_in  = (r_row - Y_OFF) < SRC_V;
    assign w_col_in  = (r_col - X_OFF) < SRC_H;
    assign w_keep    = (w_next == ST_ACTIVE) & cam_href & w_row_in & w_col_in;
    assign w_row_end = w_href_fall & w_row_in & (r_state == ST_ACTIVE);

    always_comb begin
        w_next     = r_state;
        w_skip_inc = 1'b0;
        if (w_vs_rise) begin
            if (r_skip < SKIP_N) begin
                w_next     = ST_SKIP;
                w_skip_inc = 1'b1;
            end else if (capture_en) begin
                w_next = ST_ACTIVE;
            end else begin
                w_next = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_skip  <= '0;
        end else begin
            r_state <= w_next;
            if (w_skip_inc) r_skip <= r_skip + 1'b1;
        end
    end

    // Counters saturate so an oversize sensor never wraps back into the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col      <= '0;
            r_row      <= '0;
            r_rows_out <= '0;
        end else if (w_vs_rise) begin
            r_col      <= '0;
            r_row      <= '0;
            r_rows_out <= '0;
        end else begin
            if (!cam_href)      r_col <= '0;
            else if (r_col != '1) r_col <= r_col + 1'b1;
            if (w_href_fall && r_row != '1) r_row <= r_row + 1'b1;
            if (w_row_end) r_rows_out <= r_rows_out + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_vsync       <= 1'b0;
            out_hsync       <= 1'b0;
            out_den         <= 1'b0;
            out_data        <= '0;
            frame_cnt       <= '0;
            err_short_line  <= 1'b0;
            err_short_frame <= 1'b0;
        end else begin
            out_vsync <= cam_vsync & (w_next == ST_ACTIVE);
            out_hsync <= w_keep;
            out_den   <= w_keep;
            out_data  <= w_keep ? cam_data : '0;
            if (w_vs_rise && w_next == ST_ACTIVE) frame_cnt <= frame_cnt + 16'd1;
            if (w_row_end && r_col < X_END)       err_short_line <= 1'b1;
            else if (err_clr)                     err_short_line <= 1'b0;
            if (w_vs_rise && r_state == ST_ACTIVE && r_rows_out < SRC_V) err_short_frame <= 1'b1;
            else if (err_clr)                                            err_short_frame <= 1'b0;
        end
    end
endmodule

// File: tb/tb_isp_raw_capture.sv
// Bench for isp_raw_capture: frame-level reference model checked every cycle plus directed literals.
module tb_isp_raw_capture;
    localparam int SH = 8, SV = 4, XO = 2, YO = 1, SK = 1, SENS_W = 12;

    logic        clk = 1'b0;
    logic        reset, capture_en, err_clr, cam_vsync, cam_href;
    logic [7:0]  cam_data;
    logic        out_vsync, out_hsync, out_den, err_short_line, err_short_frame;
    logic [7:0]  out_data;
    logic [15:0] frame_cnt;

    int checks = 0, failures = 0;
    int drv_col = 0, drv_row = 0;
    int den_cnt = 0;
    bit vs_seen = 0;

    // reference model state
    bit        m_vs_prev, m_href_prev, m_emit, m_esl, m_esf;
    int        m_skip, m_rows, m_prow, m_plen;
    bit [15:0] m_fc;
    bit        e_vs, e_keep;
    bit [7:0]  e_data;

    isp_raw_capture #(
        .source_h(SH), .source_v(SV), .x_off(XO), .y_off(YO), .skip_frames(SK), .cnt_w(12)
    ) dut (
        .clk(clk), .reset(reset), .capture_en(capture_en), .err_clr(err_clr),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .out_vsync(out_vsync), .out_hsync(out_hsync), .out_den(out_den), .out_data(out_data),
        .frame_cnt(frame_cnt), .err_short_line(err_short_line), .err_short_frame(err_short_frame)
    );

    always #5 clk = ~clk;

    // Model: frame emission decided per vsync from skip count and capture_en; pixel
    // position comes straight from the driver's loop indices.
    initial forever begin
        bit vr, sl_set, sf_set;
        @(posedge clk);
        if (reset) begin
            m_vs_prev = 0; m_href_prev = 0; m_emit = 0; m_esl = 0; m_esf = 0;
            m_skip = 0; m_rows = 0; m_prow = 0; m_plen = 0; m_fc = 0;
            e_vs = 0; e_keep = 0; e_data = 0;
        end else begin
            vr = cam_vsync & ~m_vs_prev;
            sl_set = 0; sf_set = 0;
            if (vr) begin
                if (m_emit && m_rows < SV) sf_set = 1;
                if (m_skip < SK) begin m_skip++; m_emit = 0; end
                else m_emit = capture_en;
                if (m_emit) m_fc++;
                m_rows = 0;
            end else if (!cam_href && m_href_prev && m_emit && m_prow >= YO && m_prow < YO + SV) begin
                m_rows++;
                if (m_plen < XO + SH) sl_set = 1;
            end
            if (cam_href) begin m_prow = drv_row; m_plen = drv_col + 1; end
            m_href_prev = cam_href;
            m_vs_prev   = cam_vsync;
            e_keep = m_emit && cam_href && drv_row >= YO && drv_row < YO + SV
                     && drv_col >= XO && drv_col < XO + SH;
            e_data = e_keep ? 8'(drv_col) : 8'h00;
            e_vs   = cam_vsync & m_emit;
            m_esl  = sl_set ? 1'b1 : (err_clr ? 1'b0 : m_esl);
            m_esf  = sf_set ? 1'b1 : (err_clr ? 1'b0 : m_esf);
        end
    end

    initial forever begin
        logic [28:0] act, exp;
        @(negedge clk);
        act = {out_vsync, out_hsync, out_den, out_data, frame_cnt, err_short_line, err_short_frame};
        exp = reset ? 29'h0 : {e_vs, e_keep, e_keep, e_data, m_fc, m_esl, m_esf};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL cycle_cmp t=%0t got=%h want=%h", $time, act, exp);
        end
        if (out_den)   den_cnt++;
        if (out_vsync) vs_seen = 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic vs, input logic hr, input int c, input int r);
        cam_vsync = vs; cam_href = hr; cam_data = hr ? 8'(c) : 8'h00;
        drv_col = c; drv_row = r;
        @(posedge clk); #2;
    endtask

    task automatic frame(input int nrows, input int srow, input int slen,
                         input int drop_row, input int rst_row, input bit lat, input bit sf_chk);
        den_cnt = 0; vs_seen = 0;
        cyc(1, 0, 0, 0);
        if (sf_chk) chk("short_frame_at_vs", int'(err_short_frame), 1);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < ((r == srow) ? slen : SENS_W); c++) begin
                if (r == drop_row && c == 0) capture_en = 0;
                if (r == rst_row && c == 4) begin
                    reset = 1; #1;
                    chk("rst_outs_zero", int'({out_vsync, out_hsync, out_den, out_data,
                        frame_cnt, err_short_line, err_short_frame}), 0);
                end
                if (r == rst_row && c == 7) reset = 0;
                if (lat && r == YO && c == XO) chk("lat_pre_den", int'(out_den), 0);
                cyc(0, 1, c, r);
                if (lat && r == YO && c == XO) begin
                    chk("lat_den", int'(out_den), 1);
                    chk("lat_data", int'(out_data), XO);
                end
            end
            for (int g = 0; g < 3; g++) cyc(0, 0, 0, r);
        end
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; capture_en = 1; err_clr = 0;
        cam_vsync = 0; cam_href = 0; cam_data = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_fc", int'(frame_cnt), 0);
        chk("reset_den", int'(out_den), 0);
        reset = 0;
        cyc(0, 0, 0, 0);

        frame(6, -1, 0, -1, -1, 0, 0);           // F1 skipped
        chk("f1_den", den_cnt, 0);
        chk("f1_vs", int'(vs_seen), 0);
        frame(6, -1, 0, -1, -1, 1, 0);           // F2 emitted, latency pinned
        chk("f2_den", den_cnt, SH * SV);
        chk("f2_vs", int'(vs_seen), 1);
        frame(6, -1, 0, -1, -1, 0, 0);           // F3
        chk("f3_den", den_cnt, SH * SV);
        chk("fc_after_f3", int'(frame_cnt), 2);

        frame(6, 2, 7, -1, -1, 0, 0);            // F4: short row 2
        chk("f4_den", den_cnt, SH * SV - 3);
        chk("esl_set", int'(err_short_line), 1);
        repeat (5) cyc(0, 0, 0, 0);
        chk("esl_sticky", int'(err_short_line), 1);
        err_clr = 1; cyc(0, 0, 0, 0); err_clr = 0;
        chk("esl_cleared", int'(err_short_line), 0);

        frame(3, -1, 0, -1, -1, 0, 0);           // F5: 3 sensor rows
        chk("f5_den", den_cnt, 2 * SH);
        chk("esf_before", int'(err_short_frame), 0);
        frame(6, -1, 0, -1, -1, 0, 1);           // F6: error at its vsync, then normal
        chk("f6_den", den_cnt, SH * SV);

        frame(6, -1, 0, 2, -1, 0, 0);            // F7: capture_en dropped mid-frame
        chk("f7_den", den_cnt, SH * SV);
        frame(6, -1, 0, -1, -1, 0, 0);           // F8 not emitted
        chk("f8_den", den_cnt, 0);
        chk("f8_vs", int'(vs_seen), 0);
        capture_en = 1;
        frame(6, -1, 0, -1, -1, 0, 0);           // F9 emitted again
        chk("f9_den", den_cnt, SH * SV);
        chk("f9_vs", int'(vs_seen), 1);

        frame(6, -1, 0, -1, 2, 0, 0);            // F10: reset during row 2
        chk("post_rst_fc", int'(frame_cnt), 0);
        frame(6, -1, 0, -1, -1, 0, 0);           // F11 skipped
        chk("f11_den", den_cnt, 0);
        frame(6, -1, 0, -1, -1, 0, 0);           // F12 emitted
        chk("f12_den", den_cnt, SH * SV);
        chk("fc_restart", int'(frame_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
